// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - Run burst sequencer driving a 2-bit counter FSM, with optional
// reference-model checker enabled by RUNSEQ_CHECK_EN.
module run_sequencer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Len,
  input  logic       Pause,
  input  logic       Y,
  output logic       Run,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] YCount,
  output logic       Mismatch,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] ycount_q, ycount_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      remaining_q <= 8'd0;
      ycount_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ycount_q    <= ycount_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ycount_d    = ycount_q;
    if (Run && Y && (ycount_q != 8'hFF)) begin
      ycount_d = ycount_q + 8'd1;
    end
    case (state_q)
      IDLE: begin
        if (Start) begin
          ycount_d = 8'd0;
          if (Len != 8'd0) begin
            remaining_d = Len;
            state_d     = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // The last counting cycle wins over a pause request.
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) begin
          state_d = DONE;
        end else if (Pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!Pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Run    = (state_q == RUN);
  assign Busy   = (state_q != IDLE);
  assign Done   = (state_q == DONE);
  assign YCount = ycount_q;

`ifdef RUNSEQ_CHECK_EN
  logic [1:0] model_q, model_d;
  logic       mismatch_q, mismatch_d;
  logic       start_accept;
  logic       exp_y;

  assign start_accept = (state_q == IDLE) && Start;
  assign exp_y        = Run && (model_q[1] || model_q[0]);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      model_q    <= 2'd0;
      mismatch_q <= 1'b0;
    end else begin
      model_q    <= model_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Model state persists across bursts; only counting cycles advance it.
  always_comb begin
    model_d    = model_q;
    mismatch_d = mismatch_q;
    if (Run) begin
      model_d = model_q + 2'd1;
    end
    if (start_accept) begin
      mismatch_d = 1'b0;
    end else if (Y != exp_y) begin
      mismatch_d = 1'b1;
    end
  end

  assign Mismatch = mismatch_q;
  assign State    = model_q;
`else
  assign Mismatch = 1'b0;
  assign State    = 2'b00;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - Randomized self-checking bench for run_sequencer.
module tb_run_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [7:0] Len;
  logic       Pause;
  logic       Y;
  logic       Run;
  logic       Busy;
  logic       Done;
  logic [7:0] YCount;
  logic       Mismatch;
  logic [1:0] State;

  int checks = 0;
  int errors = 0;

  // Environment: the real 2-bit counter FSM that answers with Y.
  logic [1:0] env_q;
  int         env_runs = 0;
  bit         force_first = 0;
  int         force_at = 0;

  // Reference: expected counter position, advanced by Len per completed burst.
  int exp_cnt = 0;

  run_sequencer dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len), .Pause(Pause), .Y(Y),
    .Run(Run), .Busy(Busy), .Done(Done), .YCount(YCount), .Mismatch(Mismatch),
    .State(State)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk or posedge Reset) begin
    if (Reset) env_q <= 2'd0;
    else if (Run) env_q <= env_q + 2'd1;
  end

  always @(posedge Clk) begin
    if (Run) env_runs <= env_runs + 1;
  end

  assign Y = Run && ((force_first && env_runs == force_at) || env_q != 2'd0);

  task automatic do_burst(input int len, input int pmode, input bit noise, input bit frc,
                          output int pauses);
    int  phase;
    int  left;
    int  runs;
    int  dones;
    int  busies;
    int  hold;
    int  yc;
    int  c0;
    bit  seen_done;
    bit  pnext;
    bit  exp_mm;
    int  exp_st;
    logic [7:0] yc_at_done;
    logic       mm_at_done;
    logic [1:0] st_at_done;
    c0 = exp_cnt;
    yc = 0;
    for (int k = 0; k < len; k++) if (((c0 + k) % 4) != 0) yc++;
    if (frc && len != 0 && c0 == 0) yc++;
    if (yc > 255) yc = 255;
`ifdef RUNSEQ_CHECK_EN
    exp_mm = frc && len != 0 && c0 == 0;
    exp_st = (c0 + len) % 4;
`else
    exp_mm = 1'b0;
    exp_st = 0;
`endif
    force_first = frc;
    force_at    = env_runs;
    Start = 1'b1;
    Len   = len[7:0];
    Pause = 1'b0;
    phase = (len == 0) ? 3 : 1;
    left = len; runs = 0; dones = 0; busies = 0; hold = 0; pauses = 0;
    seen_done = 1'b0;
    yc_at_done = 8'd0; mm_at_done = 1'b0; st_at_done = 2'd0;
    for (int cyc = 0; cyc < 1000 && !seen_done; cyc++) begin
      @(negedge Clk);
      checks++;
      if (Run !== (phase == 1)) begin
        errors++; $display("FAIL run_cycle: len=%0d cyc=%0d Run=%b expected %b", len, cyc, Run, phase == 1);
      end
      checks++;
      if (Done !== (phase == 3)) begin
        errors++; $display("FAIL done_cycle: len=%0d cyc=%0d Done=%b expected %b", len, cyc, Done, phase == 3);
      end
      checks++;
      if (Busy !== 1'b1) begin
        errors++; $display("FAIL busy_cycle: len=%0d cyc=%0d Busy=%b expected 1", len, cyc, Busy);
      end
      checks++;
      if (Mismatch !== ((runs >= 1) ? exp_mm : 1'b0)) begin
        errors++; $display("FAIL mismatch_cycle: len=%0d cyc=%0d Mismatch=%b expected %b", len, cyc, Mismatch, (runs >= 1) ? exp_mm : 1'b0);
      end
      if (cyc == 0) begin
        checks++;
        if (YCount !== 8'd0) begin
          errors++; $display("FAIL ycount_cleared: got %0d expected 0", YCount);
        end
      end
      if (Run === 1'b1) runs++;
      if (Done === 1'b1) dones++;
      if (Busy === 1'b1) busies++;
      if (pmode == 1) pnext = ($urandom_range(0, 3) == 0);
      else if (pmode == 2) begin
        if (phase == 1 && runs == 2) hold = 3;
        pnext = (hold > 0);
        if (hold > 0) hold--;
      end else pnext = 1'b0;
      case (phase)
        1: begin
          left--;
          if (left == 0) phase = 3;
          else if (pnext) phase = 2;
        end
        2: begin
          pauses++;
          if (!pnext) phase = 1;
        end
        3: begin
          seen_done = 1'b1;
          yc_at_done = YCount; mm_at_done = Mismatch; st_at_done = State;
          phase = 0;
        end
        default: phase = 0;
      endcase
      Pause = pnext && !seen_done;
      Start = (noise && !seen_done) ? 1'($urandom_range(0, 1)) : 1'b0;
      Len   = noise ? 8'($urandom) : len[7:0];
    end
    force_first = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++; $display("FAIL burst_timeout: len=%0d no Done within budget", len);
    end
    checks++;
    if (runs != len) begin
      errors++; $display("FAIL run_total: got %0d expected %0d", runs, len);
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL done_pulses: got %0d expected 1", dones);
    end
    checks++;
    if (busies != len + pauses + 1) begin
      errors++; $display("FAIL busy_total: got %0d expected %0d", busies, len + pauses + 1);
    end
    checks++;
    if (yc_at_done !== 8'(yc)) begin
      errors++; $display("FAIL ycount: len=%0d got %0d expected %0d", len, yc_at_done, yc);
    end
    checks++;
    if (mm_at_done !== exp_mm) begin
      errors++; $display("FAIL mismatch_done: got %b expected %b", mm_at_done, exp_mm);
    end
    checks++;
    if (st_at_done !== 2'(exp_st)) begin
      errors++; $display("FAIL model_state: got %0d expected %0d", st_at_done, exp_st);
    end
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0 || Run !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL idle_after: Busy=%b Run=%b Done=%b expected 000", Busy, Run, Done);
    end
    exp_cnt = (exp_cnt + len) % 4;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    Start = 1'b0; Pause = 1'b0; Len = 8'd0;
    @(negedge Clk);
    Reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Pause = 1'b0; Len = 8'd0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Run, Busy, Done, Mismatch} !== 4'b0000 || YCount !== 8'd0 || State !== 2'd0) begin
      errors++; $display("FAIL reset_state: Run=%b Busy=%b Done=%b Mm=%b YCount=%0d State=%0d expected all 0", Run, Busy, Done, Mismatch, YCount, State);
    end
    Reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_basic();
    int p;
    do_burst(5, 0, 1'b0, 1'b0, p);
  endtask

  task automatic test_pause();
    int p;
    do_burst(4, 2, 1'b0, 1'b0, p);
    checks++;
    if (p != 3) begin
      errors++; $display("FAIL pause_cycles: got %0d expected 3", p);
    end
  endtask

  task automatic test_zero_len();
    int p;
    do_burst(0, 0, 1'b0, 1'b0, p);
    do_burst(0, 1, 1'b1, 1'b0, p);
  endtask

  task automatic test_mismatch();
    int p;
    apply_reset();
    do_burst($urandom_range(3, 9), 1, 1'b0, 1'b1, p);
    do_burst($urandom_range(1, 6), 0, 1'b0, 1'b0, p);
  endtask

  task automatic test_random();
    int p;
    for (int i = 0; i < 20; i++) begin
      do_burst($urandom_range(0, 40), 1, 1'b1, 1'b0, p);
    end
    do_burst(255, 0, 1'b1, 1'b0, p);
  endtask

  task automatic test_reset_mid_run(input bit in_pause);
    int p;
    Start = 1'b1; Len = 8'd200; Pause = 1'b0;
    @(negedge Clk);
    repeat (30) begin
      Start = 1'($urandom_range(0, 1));
      Len   = 8'($urandom);
      @(negedge Clk);
    end
    Start = 1'b0;
    if (in_pause) begin
      Pause = 1'b1;
      repeat (2) @(negedge Clk);
      checks++;
      if (Run !== 1'b0 || Busy !== 1'b1) begin
        errors++; $display("FAIL paused_hold: Run=%b Busy=%b expected 0 1", Run, Busy);
      end
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Run, Busy, Done, Mismatch} !== 4'b0000 || YCount !== 8'd0 || State !== 2'd0) begin
      errors++; $display("FAIL reset_async: Run=%b Busy=%b Done=%b Mm=%b YCount=%0d State=%0d expected all 0", Run, Busy, Done, Mismatch, YCount, State);
    end
    #1 Reset = 1'b0;
    Pause = 1'b0;
    exp_cnt = 0;
    do_burst($urandom_range(1, 8), 0, 1'b0, 1'b0, p);
  endtask

  initial begin
    test_reset();
    @(negedge Clk);
    test_basic();
    test_pause();
    test_zero_len();
    test_mismatch();
    test_random();
    test_reset_mid_run(1'b0);
    test_reset_mid_run(1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 The block SHALL have port Clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port Start, input, 1 bit: request a run burst; sampled only in IDLE.
REQ-004 The block SHALL have port Len, input, 8 bits: number of counting cycles (Run-high cycles) in the burst; captured with Start.
REQ-005 The block SHALL have port Pause, input, 1 bit: suspend the burst without losing progress.
REQ-006 The block SHALL have port Y, input, 1 bit: y output returned by the 2-bit counter FSM that this block drives.
REQ-007 The block SHALL have port Run, output, 1 bit: count enable to the counter FSM.
REQ-008 The block SHALL have port Busy, output, 1 bit: high whenever state is not IDLE.
REQ-009 The block SHALL have port Done, output, 1 bit: single-cycle burst-complete pulse.
REQ-010 The block SHALL have port YCount, output, 8 bits: number of burst cycles with Y=1.
REQ-011 The block SHALL have port Mismatch, output, 1 bit: sticky flag; observed Y differed from expected y.
REQ-012 The block SHALL have port State, output, 2 bits: model counter state {QA,QB}.

Function
REQ-013 FSM states SHALL be IDLE, RUN, PAUSE and DONE; Run SHALL equal 1 exactly when state is RUN, decoded from the state register.
REQ-014 In IDLE, Start=1 with Len!=0 SHALL load Remaining=Len, clear YCount and Mismatch, and go to RUN; Start=1 with Len=0 SHALL clear YCount and Mismatch and go directly to DONE (no Run cycles).
REQ-015 In RUN, each cycle SHALL decrement Remaining; Remaining=1 SHALL go to DONE (this takes priority over Pause); otherwise Pause=1 SHALL go to PAUSE, else stay in RUN.
REQ-016 PAUSE SHALL hold while Pause=1, return to RUN when Pause=0, and keep Remaining unchanged.
REQ-017 DONE SHALL assert Done for exactly one cycle and then go to IDLE.
REQ-018 Total Run-high cycles per burst SHALL equal Len exactly, independent of pause cycles.
REQ-019 Start SHALL be ignored outside IDLE, with no effect on Len capture or state.
REQ-020 Model counter: each cycle with Run=1, QB SHALL toggle and QA SHALL toggle iff QB was 1 (mod-4 increment); the model SHALL hold otherwise and persist across bursts.
REQ-021 Expected y SHALL be Run AND (QA OR QB) of the current model state, compared combinationally against Y in the same cycle.
REQ-022 YCount SHALL increment in each cycle with Run=1 and Y=1, saturating at 255.
REQ-023 Mismatch SHALL set on any cycle where Y differs from expected y, and SHALL clear only on an accepted Start or on Reset.

Reset
REQ-024 Reset=1 SHALL immediately force state to IDLE, set Run, Busy, Done and Mismatch to 0, set YCount, Remaining and State to 0, and abort any burst in progress, including one mid-RUN or mid-PAUSE.
REQ-025 After Reset deasserts, the first Start SHALL be accepted on the first rising edge.

Configuration
REQ-026 With RUNSEQ_CHECK_EN defined, the model counter, comparator, Mismatch and State SHALL be implemented as specified.
REQ-027 Without RUNSEQ_CHECK_EN, the model and comparator SHALL be omitted, Mismatch and State SHALL be tied to 0, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Reset, then Start with Len=5 and a correct counter model on Y -> Run high for 5 cycles, Y pattern 0,1,1,1,0, YCount=3, State=01, one Done pulse, Mismatch=0.
REQ-029 Start with Len=4; Pause=1 for 3 cycles after the 2nd Run cycle -> Run low for 3 cycles, total Run-high cycles=4, Done one cycle after the last Run cycle.
REQ-030 Start with Len=0 -> no Run cycles, Done pulse one cycle later, Busy high for 1 cycle, YCount=0.
REQ-031 Y forced to 1 during the first Run cycle (model state 00) -> Mismatch=1 and stays 1 through Done; the next accepted Start clears it.
REQ-032 Reset asserted mid-RUN with Len=200 -> Run, Busy and YCount go to 0 immediately; Start pulses during a burst are ignored with no change to Remaining.
REQ-033 Build without RUNSEQ_CHECK_EN and repeat REQ-031 -> Mismatch=0, State=00, while Run, Done and YCount match the checked build.
